// File: rtl/fp16_recip_mul.sv
// FP16 divide back end: multiplies numerator x by the reciprocal 1/y with a
// serial shift-add mantissa multiplier, then normalizes, rounds and saturates.
module fp16_recip_mul #(
    parameter int WAIT_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] num,
    input  logic        num_valid,
    input  logic [15:0] recip,
    input  logic        recip_complete,
    output logic [15:0] quot,
    output logic        quot_valid,
    output logic        busy,
    output logic        err
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);
    localparam logic [3:0] ITER_LAST = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RECIP,
        MULT,
        NORM,
        DONE
    } state_t;

    state_t            state;
    logic [15:0]       xr;
    logic [15:0]       yr;
    logic [CNT_W-1:0]  wait_cnt;
    logic [3:0]        iter;
    logic [21:0]       p;

    logic [10:0]       ma;
    logic [10:0]       mb;
    logic [21:0]       addend;
    logic              sgn;
    logic signed [6:0] e_sum;
    logic [15:0]       result;

    // Normalize the 22-bit product, round half-up on the guard bit, then
    // clamp: overflow saturates to max finite, underflow flushes to zero.
    function automatic logic [15:0] round_sat(input logic s,
                                              input logic signed [6:0] e,
                                              input logic [21:0] prod);
        logic signed [7:0] ex;
        logic [10:0]       fr;
        logic              g;
        ex = $signed({e[6], e});
        if (prod[21]) begin
            fr = {1'b0, prod[20:11]};
            g  = prod[10];
            ex = ex + 8'sd1;
        end else begin
            fr = {1'b0, prod[19:10]};
            g  = prod[9];
        end
        fr = fr + {10'b0, g};
        if (fr[10]) begin
            fr = 11'b0;
            ex = ex + 8'sd1;
        end
        if (ex >= 8'sd31)
            round_sat = {s, 15'h7BFF};
        else if (ex <= 8'sd0)
            round_sat = {s, 15'h0000};
        else
            round_sat = {s, ex[4:0], fr[9:0]};
    endfunction

    always_comb begin
        ma     = {1'b1, xr[9:0]};
        mb     = {1'b1, yr[9:0]};
        addend = mb[iter] ? ({11'b0, ma} << iter) : 22'b0;
        sgn    = xr[15] ^ yr[15];
        e_sum  = $signed({2'b00, xr[14:10]}) + $signed({2'b00, yr[14:10]}) - 7'sd15;
        // Zero/subnormal operands dominate; the multiplier still runs so latency is fixed.
        if (xr[14:10] == 5'd0 || yr[14:10] == 5'd0)
            result = {sgn, 15'h0000};
        else if (xr[14:10] == 5'h1F || yr[14:10] == 5'h1F)
            result = {sgn, 15'h7BFF};
        else
            result = round_sat(sgn, e_sum, p);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            xr         <= 16'h0000;
            yr         <= 16'h0000;
            wait_cnt   <= '0;
            iter       <= 4'd0;
            p          <= 22'b0;
            quot       <= 16'h0000;
            quot_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    quot_valid <= 1'b0;
                    err        <= 1'b0;
                    if (num_valid) begin
                        xr       <= num;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= WAIT_RECIP;
                    end
                end
                WAIT_RECIP: begin
                    if (recip_complete) begin
                        yr    <= recip;
                        p     <= 22'b0;
                        iter  <= 4'd0;
                        state <= MULT;
                    end else if (wait_cnt == CNT_LAST) begin
                        quot       <= 16'h7E00;
                        err        <= 1'b1;
                        quot_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                MULT: begin
                    p <= p + addend;
                    if (iter == ITER_LAST) begin
                        iter  <= 4'd0;
                        state <= NORM;
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end
                NORM: begin
                    quot       <= result;
                    quot_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    quot_valid <= 1'b0;
                    err        <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_recip_mul.sv
// Directed bench for fp16_recip_mul: vector table plus protocol, timeout and
// mid-operation reset sequences.
module tb_fp16_recip_mul;

    localparam int WL = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] num = 16'h0000;
    logic        num_valid = 1'b0;
    logic [15:0] recip = 16'h0000;
    logic        recip_complete = 1'b0;
    logic [15:0] quot;
    logic        quot_valid;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    fp16_recip_mul #(.WAIT_LIMIT(WL)) dut (
        .clk            (clk),
        .rst            (rst),
        .num            (num),
        .num_valid      (num_valid),
        .recip          (recip),
        .recip_complete (recip_complete),
        .quot           (quot),
        .quot_valid     (quot_valid),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] q;
        int          delay;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One full operation; t0 is the edge sampling recip_complete, and k counts
    // edges after t0 (outputs sampled on the falling edge after edge t0+k).
    task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] exp_q, input int delay,
                          input bit coincide, input bit hold2, input bit nv_mult);
        int lat;
        int pulses;
        int busy_bad;
        logic [15:0] got_q;
        logic got_err;
        lat = -1; pulses = 0; busy_bad = 0; got_q = 16'h0; got_err = 1'b0;
        @(negedge clk);
        num = x; num_valid = 1'b1;
        if (coincide) begin
            recip = 16'h7BFF; recip_complete = 1'b1;
        end
        @(negedge clk);
        num_valid = 1'b0; recip_complete = 1'b0; num = 16'h0000;
        if (quot_valid) pulses++;
        if (!busy) busy_bad++;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            if (quot_valid) pulses++;
            if (!busy) busy_bad++;
        end
        recip = y; recip_complete = 1'b1;
        @(negedge clk);
        if (!hold2) recip_complete = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (quot_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; got_q = quot; got_err = err;
                end
            end
            if (k <= 12 && !busy) busy_bad++;
            if (k >= 13 && busy) busy_bad++;
            recip_complete = 1'b0;
            num = 16'h3C00;
            num_valid = (nv_mult && k == 4);
        end
        num_valid = 1'b0;
        check({name, "_quot"}, int'(got_q), int'(exp_q));
        check({name, "_latency"}, lat, 12);
        check({name, "_pulses"}, pulses, 1);
        check({name, "_err"}, int'(got_err), 0);
        check({name, "_busy"}, busy_bad, 0);
        check({name, "_hold"}, int'(quot), int'(exp_q));
    endtask

    task automatic run_timeout();
        int lat;
        int pulses;
        int err_cnt;
        logic [15:0] got_q;
        logic got_err;
        logic idle_busy;
        lat = -1; pulses = 0; err_cnt = 0; got_q = 16'h0; got_err = 1'b0; idle_busy = 1'b1;
        @(negedge clk);
        num = 16'h4200; num_valid = 1'b1;
        @(negedge clk);
        num_valid = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (err) err_cnt++;
            if (quot_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; got_q = quot; got_err = err;
                end
            end
            if (k == 65) idle_busy = busy;
        end
        check("timeout_latency", lat, WL);
        check("timeout_quot", int'(got_q), 16'h7E00);
        check("timeout_err", int'(got_err), 1);
        check("timeout_pulses", pulses, 1);
        check("timeout_err_cycles", err_cnt, 1);
        check("timeout_idle", int'(idle_busy), 0);
    endtask

    task automatic run_reset_abort();
        int pulses;
        pulses = 0;
        @(negedge clk);
        num = 16'h3C00; num_valid = 1'b1;
        @(negedge clk);
        num_valid = 1'b0;
        recip = 16'h4000; recip_complete = 1'b1;
        @(negedge clk);
        recip_complete = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_quot", int'(quot), 0);
        check("rst_quot_valid", int'(quot_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (quot_valid || busy) pulses++;
        end
        check("rst_no_result", pulses, 0);
    endtask

    initial begin
        vecs[0]  = '{16'h4200, 16'h3800, 16'h3E00, 2};
        vecs[1]  = '{16'hC200, 16'h3800, 16'hBE00, 0};
        vecs[2]  = '{16'h8000, 16'h3800, 16'h8000, 1};
        vecs[3]  = '{16'h0123, 16'h4000, 16'h0000, 2};
        vecs[4]  = '{16'h3C01, 16'h3C01, 16'h3C02, 1};
        vecs[5]  = '{16'h3E00, 16'h3C01, 16'h3E02, 0};
        vecs[6]  = '{16'h3FFF, 16'h3FFF, 16'h43FE, 3};
        vecs[7]  = '{16'h7BFF, 16'h7BFF, 16'h7BFF, 1};
        vecs[8]  = '{16'hFBFF, 16'h7BFF, 16'hFBFF, 1};
        vecs[9]  = '{16'h0400, 16'h0400, 16'h0000, 0};
        vecs[10] = '{16'h0400, 16'h3800, 16'h0000, 1};
        vecs[11] = '{16'h0400, 16'h3C00, 16'h0400, 1};
        vecs[12] = '{16'h7800, 16'h4000, 16'h7BFF, 0};
        vecs[13] = '{16'h7800, 16'h3C00, 16'h7800, 2};
        vecs[14] = '{16'h7C00, 16'h3800, 16'h7BFF, 1};
        vecs[15] = '{16'h3800, 16'hC000, 16'hBC00, 0};
        vecs[16] = '{16'h3BFE, 16'h3C01, 16'h3C00, 1};

        repeat (2) @(negedge clk);
        check("reset_quot", int'(quot), 0);
        check("reset_quot_valid", int'(quot_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].q,
                   vecs[i].delay, 1'b0, 1'b0, 1'b0);

        run_op("coincide", 16'h4200, 16'h3800, 16'h3E00, 3, 1'b1, 1'b0, 1'b0);
        run_op("hold2", 16'hC200, 16'h4000, 16'hC600, 1, 1'b0, 1'b1, 1'b0);
        run_op("nv_mult", 16'h3C00, 16'h4000, 16'h4000, 0, 1'b0, 1'b0, 1'b1);

        run_timeout();
        run_op("after_timeout", 16'h4200, 16'h3800, 16'h3E00, 1, 1'b0, 1'b0, 1'b0);

        run_reset_abort();
        run_op("after_reset", 16'hC200, 16'h3800, 16'hBE00, 2, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
